// File: rtl/reaction_ctrl.sv
// rtl/reaction_ctrl.sv - reaction-time tester controller driving an external BCD stopwatch
//
// Purpose: waits a pseudo-random delay after start, lights the lamp, times the
// player's reaction with an external millisecond stopwatch and reports the
// result as valid, false start (stop pressed before the lamp) or timeout (999 ms).
// Optional feature macro: REACTION_CTRL_BEST_EN adds the best_time output/register.
//
// Ports:
//   clk           clock
//   clr           asynchronous active-high reset
//   start_btn     one-cycle start pulse
//   stop_btn      one-cycle reaction pulse
//   sw_d2/d1/d0   stopwatch BCD digits (hundreds/tens/units ms)
//   sw_done_tick  stopwatch has stopped
//   sw_clr        stopwatch clear (ARM cycle)
//   sw_start      stopwatch start (first TIMING cycle)
//   sw_stop       stopwatch stop (whole STOP state)
//   led           stimulus lamp
//   busy          test in progress
//   result        BCD {d2,d1,d0} of the last test
//   status        00 none, 01 valid, 10 false start, 11 timeout
//   best_time     best valid result (REACTION_CTRL_BEST_EN only)

module reaction_ctrl #(
  parameter int          DVSR_MS      = 50000,
  parameter int          MIN_DELAY_MS = 2000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start_btn,
  input  logic        stop_btn,
  input  logic [3:0]  sw_d2,
  input  logic [3:0]  sw_d1,
  input  logic [3:0]  sw_d0,
  input  logic        sw_done_tick,
  output logic        sw_clr,
  output logic        sw_start,
  output logic        sw_stop,
  output logic        led,
  output logic        busy,
  output logic [11:0] result,
`ifdef REACTION_CTRL_BEST_EN
  output logic [11:0] best_time,
`endif
  output logic [1:0]  status
);

  localparam int             PW        = (DVSR_MS > 1) ? $clog2(DVSR_MS) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(DVSR_MS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ARM    = 3'd2,
    S_TIMING = 3'd3,
    S_STOP   = 3'd4,
    S_RESULT = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [15:0]   delay_q, delay_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [11:0]   result_q, result_d;
  logic [1:0]    status_q, status_d;
  logic          timeout_q, timeout_d;
  logic          first_q, first_d;
  logic [11:0]   sw_bcd;

  assign sw_bcd = {sw_d2, sw_d1, sw_d0};

  // Fibonacci LFSR, taps 16,14,13,11; a nonzero seed keeps it off the all-zero lock-up state.
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

`ifdef REACTION_CTRL_BEST_EN
  logic [11:0] best_q, best_d;
`endif

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    presc_d   = presc_q;
    result_d  = result_q;
    status_d  = status_q;
    timeout_d = timeout_q;
    first_d   = 1'b0;
`ifdef REACTION_CTRL_BEST_EN
    best_d    = best_q;
`endif
    case (state_q)
      S_IDLE, S_RESULT: begin
        if (start_btn) begin
          state_d   = S_WAIT;
          delay_d   = 16'(MIN_DELAY_MS) + {4'd0, lfsr_q[11:0]};
          presc_d   = '0;
          timeout_d = 1'b0;
        end
      end
      S_WAIT: begin
        // A stop during the dark period is a false start, even on the expiry cycle.
        if (stop_btn) begin
          state_d  = S_RESULT;
          result_d = 12'h000;
          status_d = 2'b10;
        end else if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          if (delay_q == 16'd0) state_d = S_ARM;
          else                  delay_d = delay_q - 16'd1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      S_ARM: begin
        state_d = S_TIMING;
        first_d = 1'b1;
      end
      S_TIMING: begin
        if (stop_btn) begin
          state_d = S_STOP;
        end else if (sw_bcd == 12'h999) begin
          state_d   = S_STOP;
          timeout_d = 1'b1;
        end
      end
      S_STOP: begin
        if (sw_done_tick) begin
          state_d  = S_RESULT;
          result_d = sw_bcd;
          status_d = timeout_q ? 2'b11 : 2'b01;
`ifdef REACTION_CTRL_BEST_EN
          // Packed BCD orders the same as the decimal value, so a plain compare works.
          if (!timeout_q && (sw_bcd < best_q)) best_d = sw_bcd;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_SEED;
      delay_q   <= '0;
      presc_q   <= '0;
      result_q  <= 12'h000;
      status_q  <= 2'b00;
      timeout_q <= 1'b0;
      first_q   <= 1'b0;
`ifdef REACTION_CTRL_BEST_EN
      best_q    <= 12'h999;
`endif
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      delay_q   <= delay_d;
      presc_q   <= presc_d;
      result_q  <= result_d;
      status_q  <= status_d;
      timeout_q <= timeout_d;
      first_q   <= first_d;
`ifdef REACTION_CTRL_BEST_EN
      best_q    <= best_d;
`endif
    end
  end

  // Stopwatch/lamp controls decode registered state only.
  assign sw_clr   = (state_q == S_ARM);
  assign sw_start = first_q;
  assign sw_stop  = (state_q == S_STOP);
  assign led      = (state_q == S_TIMING);
  assign busy     = (state_q == S_WAIT) || (state_q == S_ARM) ||
                    (state_q == S_TIMING) || (state_q == S_STOP);
  assign result   = result_q;
  assign status   = status_q;
`ifdef REACTION_CTRL_BEST_EN
  assign best_time = best_q;
`endif

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb/tb_reaction_ctrl.sv - randomized self-checking bench for reaction_ctrl

module tb_reaction_ctrl;

  localparam int          DVSR = 4;
  localparam int          MIN  = 2;
  localparam logic [15:0] SEED = 16'h0001;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start_btn = 1'b0;
  logic        stop_btn = 1'b0;
  logic [3:0]  sw_d2, sw_d1, sw_d0;
  logic        sw_done_tick;
  logic        sw_clr, sw_start, sw_stop, led, busy;
  logic [11:0] result;
  logic [1:0]  status;
`ifdef REACTION_CTRL_BEST_EN
  logic [11:0] best_time;
`endif

  reaction_ctrl #(.DVSR_MS(DVSR), .MIN_DELAY_MS(MIN), .LFSR_SEED(SEED)) dut (
    .clk(clk), .clr(clr), .start_btn(start_btn), .stop_btn(stop_btn),
    .sw_d2(sw_d2), .sw_d1(sw_d1), .sw_d0(sw_d0), .sw_done_tick(sw_done_tick),
    .sw_clr(sw_clr), .sw_start(sw_start), .sw_stop(sw_stop), .led(led), .busy(busy),
    .result(result),
`ifdef REACTION_CTRL_BEST_EN
    .best_time(best_time),
`endif
    .status(status)
  );

  always #5 clk = ~clk;

  // Reference LFSR: shift left, feedback is parity of taps 16,14,13,11.
  logic [15:0] m_lfsr;
  always @(posedge clk or posedge clr) begin
    if (clr) m_lfsr <= SEED;
    else     m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
  end

  // Stopwatch model: decimal ms count, one ms per clock while running.
  int   sw_cnt;
  logic sw_run, sw_done;
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      sw_cnt <= 0; sw_run <= 1'b0; sw_done <= 1'b0;
    end else begin
      sw_done <= 1'b0;
      if (sw_clr) begin
        sw_cnt <= 0; sw_run <= 1'b0;
      end else if (sw_start) begin
        sw_run <= 1'b1;
      end else if (sw_stop) begin
        if (sw_run) sw_done <= 1'b1;
        sw_run <= 1'b0;
      end else if (sw_run && sw_cnt < 999) begin
        sw_cnt <= sw_cnt + 1;
      end
    end
  end
  assign sw_d2 = 4'(sw_cnt / 100);
  assign sw_d1 = 4'((sw_cnt / 10) % 10);
  assign sw_d0 = 4'(sw_cnt % 10);
  assign sw_done_tick = sw_done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_clr, n_start, n_stop;
  logic [11:0] exp_result = 12'h000;
  logic [1:0]  exp_status = 2'b00;
  int          best_m = 999;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    if (sw_clr)   n_clr++;
    if (sw_start) n_start++;
    if (sw_stop)  n_stop++;
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check_best();
`ifdef REACTION_CTRL_BEST_EN
    check("best_time", best_time, to_bcd(best_m));
`endif
  endtask

  // kind: 0 valid, 1 false start, 2 timeout, 3 clr during timing
  task automatic run_test(input int kind, input int target, input bit both);
    int d, w, k;
    logic [1:0] prev;
    k = 0;
    while (m_lfsr[11:0] >= 12'd256 && k < 4000) begin tick(); k++; end
    d = MIN + int'(m_lfsr[11:0]);
    prev = exp_status;
    n_clr = 0; n_start = 0; n_stop = 0;
    start_btn = 1'b1; stop_btn = both;
    tick();
    start_btn = 1'b0; stop_btn = 1'b0;
    check("busy_on_start", busy, 1);
    check("status_hold_on_start", status, prev);
    check("led_dark_in_wait", led, 0);
    if (kind == 1) begin
      tick(); tick();
      stop_btn = 1'b1;
      tick();
      stop_btn = 1'b0;
      exp_result = 12'h000; exp_status = 2'b10;
      check("fs_no_sw_start", n_start, 0);
      check("fs_no_sw_clr", n_clr, 0);
    end else begin
      w = 1; k = 0;
      while (!sw_clr && k < 2000) begin tick(); if (!sw_clr) w++; k++; end
      check("arm_reached", sw_clr, 1);
      check("wait_cycles", w, (d + 1) * DVSR);
      tick();
      check("arm_one_cycle", sw_clr, 0);
      check("first_timing_start", sw_start, 1);
      check("first_timing_led", led, 1);
      tick();
      check("start_one_cycle", sw_start, 0);
      check("led_in_timing", led, 1);
      if (kind == 3) begin
        repeat (3) tick();
        clr = 1'b1;
        #1;
        check("clr_led", led, 0);
        check("clr_busy", busy, 0);
        check("clr_status", status, 0);
        check("clr_result", result, 0);
        @(negedge clk);
        clr = 1'b0;
        exp_result = 12'h000; exp_status = 2'b00; best_m = 999;
        check_best();
        return;
      end
      k = 0;
      if (kind == 0) begin
        while (sw_cnt != target - 1 && k < 1200) begin tick(); k++; end
        stop_btn = 1'b1;
        tick();
        stop_btn = 1'b0;
        check("stop_led_off", led, 0);
        check("stop_sw_stop", sw_stop, 1);
        exp_result = to_bcd(target); exp_status = 2'b01;
        if (target < best_m) best_m = target;
      end else begin
        while (led && k < 1200) begin tick(); k++; end
        check("timeout_sw_stop", sw_stop, 1);
        exp_result = 12'h999; exp_status = 2'b11;
      end
      k = 0;
      while (busy && k < 20) begin tick(); k++; end
      check("sw_clr_count", n_clr, 1);
      check("sw_start_count", n_start, 1);
    end
    check("result", result, exp_result);
    check("status", status, exp_status);
    check("busy_done", busy, 0);
    check("led_done", led, 0);
    check_best();
    repeat (2) tick();
    check("result_hold", result, exp_result);
    check("status_hold", status, exp_status);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_result", result, 0);
    check("rst_status", status, 0);
    check("rst_led", led, 0);
    check("rst_busy", busy, 0);
    check("rst_sw_ctrl", {sw_clr, sw_start, sw_stop}, 0);
    check_best();
    clr = 1'b0;
    tick();

    run_test(0, 47, 1'b0);
    run_test(1, 0, 1'b0);
    run_test(2, 0, 1'b0);
    run_test(3, 0, 1'b0);
    run_test(0, 123, 1'b1);
    run_test(0, 250, 1'b0);
    run_test(0, 180, 1'b0);
    run_test(0, 300, 1'b0);
    for (int i = 0; i < 6; i++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      run_test(kind, int'($urandom_range(10, 600)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
